// File: rtl/luma_histogram_if.sv
// Pixel-in / luma-out / histogram-dump signal bundle for luma_histogram.
// master drives the pixel stream and observes results; slave is the converter.
interface luma_histogram_if #(
  parameter int BIN_WIDTH = 19
);
  logic                 frame_start;
  logic                 de;
  logic [23:0]          rgb_data;
  logic [7:0]           luma_out;
  logic                 luma_valid;
  logic [7:0]           hist_bin;
  logic [BIN_WIDTH-1:0] hist_count;
  logic                 hist_valid;
  logic                 hist_last;
  logic                 busy;

  modport master (
    output frame_start, de, rgb_data,
    input  luma_out, luma_valid, hist_bin, hist_count, hist_valid, hist_last, busy
  );

  modport slave (
    input  frame_start, de, rgb_data,
    output luma_out, luma_valid, hist_bin, hist_count, hist_valid, hist_last, busy
  );
endinterface

// File: rtl/luma_histogram.sv
// RGB to 8-bit luma with a fixed 2-cycle pipeline, plus a 256-bin per-frame
// luma histogram that is streamed out once and cleared as it is read.
module luma_histogram #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int BIN_WIDTH = 19
) (
  input  logic            clk,
  input  logic            rst,
  luma_histogram_if.slave bus
);

  localparam int TOTAL = H_ACTIVE * V_ACTIVE;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0]     TOTAL_CNT = CNT_W'(TOTAL);
  localparam logic [BIN_WIDTH-1:0] COUNT_MAX = '1;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_DUMP
  } state_e;

  logic [14:0] r_prod_d, r_prod_q;
  logic [15:0] g_prod_d, g_prod_q;
  logic [12:0] b_prod_d, b_prod_q;
  logic        de_s1_d, de_s1_q;
  logic [7:0]  luma_d, luma_q;
  logic        luma_valid_d, luma_valid_q;

  state_e               state_d, state_q;
  logic [7:0]           idx_d, idx_q;
  logic [CNT_W-1:0]     pixel_cnt_d, pixel_cnt_q;
  logic                 acc_v_d, acc_v_q;
  logic [7:0]           acc_addr_d, acc_addr_q;
  logic                 last_wr_v_d, last_wr_v_q;
  logic [7:0]           last_wr_addr_d, last_wr_addr_q;
  logic [BIN_WIDTH-1:0] last_wr_data_d, last_wr_data_q;
  logic                 hist_valid_d, hist_valid_q;
  logic [7:0]           hist_bin_d, hist_bin_q;
  logic                 hist_last_d, hist_last_q;

  logic [BIN_WIDTH-1:0] ram [256];
  logic [BIN_WIDTH-1:0] ram_rd_d, ram_rd_q;
  logic [7:0]           ram_raddr;
  logic [7:0]           ram_waddr;
  logic                 ram_we;
  logic [BIN_WIDTH-1:0] ram_wdata;
  logic [BIN_WIDTH-1:0] cur_count;
  logic [BIN_WIDTH-1:0] inc_count;

  // Coefficients sum to 256, so the rounded 16-bit sum never exceeds 65408.
  always_comb begin
    r_prod_d     = 15'd77 * {7'd0, bus.rgb_data[23:16]};
    g_prod_d     = 16'd150 * {8'd0, bus.rgb_data[15:8]};
    b_prod_d     = 13'd29 * {5'd0, bus.rgb_data[7:0]};
    de_s1_d      = bus.de;
    luma_d       = 8'(({1'b0, r_prod_q} + g_prod_q + {3'b0, b_prod_q} + 16'd128) >> 8);
    luma_valid_d = de_s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prod_q     <= '0;
      g_prod_q     <= '0;
      b_prod_q     <= '0;
      de_s1_q      <= 1'b0;
      luma_q       <= '0;
      luma_valid_q <= 1'b0;
    end else begin
      r_prod_q     <= r_prod_d;
      g_prod_q     <= g_prod_d;
      b_prod_q     <= b_prod_d;
      de_s1_q      <= de_s1_d;
      luma_q       <= luma_d;
      luma_valid_q <= luma_valid_d;
    end
  end

  assign ram_rd_d = ram[ram_raddr];

  always_ff @(posedge clk) begin
    ram_rd_q <= ram_rd_d;
    if (ram_we) begin
      ram[ram_waddr] <= ram_wdata;
    end
  end

  // A read issued in the same cycle as a write to that bin sees stale data,
  // so the value just written is substituted.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    pixel_cnt_d    = pixel_cnt_q;
    acc_v_d        = 1'b0;
    acc_addr_d     = luma_q;
    hist_valid_d   = 1'b0;
    hist_bin_d     = '0;
    hist_last_d    = 1'b0;
    ram_raddr      = luma_q;
    cur_count      = (last_wr_v_q && (last_wr_addr_q == acc_addr_q)) ? last_wr_data_q : ram_rd_q;
    inc_count      = (cur_count == COUNT_MAX) ? cur_count : cur_count + 1'b1;
    ram_we         = acc_v_q;
    ram_waddr      = acc_addr_q;
    ram_wdata      = inc_count;
    last_wr_v_d    = acc_v_q;
    last_wr_addr_d = acc_addr_q;
    last_wr_data_d = inc_count;

    case (state_q)
      S_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = idx_q;
        ram_wdata = '0;
        idx_d     = idx_q + 8'd1;
        if (idx_q == 8'd255) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (bus.frame_start) begin
          state_d     = S_ACCUM;
          pixel_cnt_d = '0;
        end
      end
      S_ACCUM: begin
        if (luma_valid_q) begin
          acc_v_d     = 1'b1;
          pixel_cnt_d = pixel_cnt_q + 1'b1;
          if ((pixel_cnt_q + 1'b1) == TOTAL_CNT) begin
            state_d = S_DRAIN;
            idx_d   = '0;
          end
        end
      end
      S_DRAIN: begin
        idx_d = idx_q + 8'd1;
        if (idx_q == 8'd1) begin
          state_d = S_DUMP;
          idx_d   = '0;
        end
      end
      S_DUMP: begin
        ram_raddr    = idx_q;
        ram_we       = 1'b1;
        ram_waddr    = idx_q;
        ram_wdata    = '0;
        hist_valid_d = 1'b1;
        hist_bin_d   = idx_q;
        hist_last_d  = (idx_q == 8'd255);
        idx_d        = idx_q + 8'd1;
        if (idx_q == 8'd255) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_CLEAR;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_CLEAR;
      idx_q          <= '0;
      pixel_cnt_q    <= '0;
      acc_v_q        <= 1'b0;
      acc_addr_q     <= '0;
      last_wr_v_q    <= 1'b0;
      last_wr_addr_q <= '0;
      last_wr_data_q <= '0;
      hist_valid_q   <= 1'b0;
      hist_bin_q     <= '0;
      hist_last_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      pixel_cnt_q    <= pixel_cnt_d;
      acc_v_q        <= acc_v_d;
      acc_addr_q     <= acc_addr_d;
      last_wr_v_q    <= last_wr_v_d;
      last_wr_addr_q <= last_wr_addr_d;
      last_wr_data_q <= last_wr_data_d;
      hist_valid_q   <= hist_valid_d;
      hist_bin_q     <= hist_bin_d;
      hist_last_q    <= hist_last_d;
    end
  end

  // busy stays up through the final dump beat, dropping the cycle after it.
  assign bus.luma_out   = luma_q;
  assign bus.luma_valid = luma_valid_q;
  assign bus.hist_bin   = hist_bin_q;
  assign bus.hist_count = hist_valid_q ? ram_rd_q : '0;
  assign bus.hist_valid = hist_valid_q;
  assign bus.hist_last  = hist_last_q;
  assign bus.busy       = (state_q != S_IDLE) || hist_valid_q;

endmodule

// File: tb/tb_luma_histogram.sv
// Directed bench for luma_histogram on a reduced 16x8 frame: luma pipeline,
// per-frame dump contents and timing, forwarding, clear-on-read and reset.
module tb_luma_histogram;

  localparam int H     = 16;
  localparam int V     = 8;
  localparam int TOTAL = H * V;
  localparam int BW    = 19;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cycle = 0;
  int   compareCount = 0;
  int   failCount = 0;

  luma_histogram_if #(.BIN_WIDTH(BW)) bus ();

  luma_histogram #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .BIN_WIDTH(BW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Expected luma pipeline and histogram, owned by the stimulus process.
  logic       expV1 = 1'b0, expV2 = 1'b0;
  logic [7:0] expL1 = 8'd0, expL2 = 8'd0;
  int         expHist [256];
  bit         armed = 1'b0;
  int         epoch = 0;

  // Dump/accumulation observations, owned by the monitor below.
  int seenEpoch = 0;
  int dumpLen = 0, orderErr = 0, lastCount = 0, lastBin = 0;
  int firstCycle = 0, lastValidCycle = 0, accCount = 0, lastPixCycle = 0;
  bit prevLast = 1'b0, busyAtLast = 1'b0, busyAfterLast = 1'b1;
  int dumpCnt [256];

  // Records every dump beat and the cycle of the last pixel counted into a frame.
  always @(negedge clk) begin
    if (epoch != seenEpoch) begin
      seenEpoch      <= epoch;
      dumpLen        <= 0;
      orderErr       <= 0;
      lastCount      <= 0;
      lastBin        <= 0;
      firstCycle     <= 0;
      lastValidCycle <= 0;
      accCount       <= 0;
      lastPixCycle   <= 0;
      prevLast       <= 1'b0;
      busyAtLast     <= 1'b0;
      busyAfterLast  <= 1'b1;
      for (int b = 0; b < 256; b++) dumpCnt[b] <= 0;
    end else begin
      prevLast <= bus.hist_last;
      if (prevLast) busyAfterLast <= bus.busy;
      if (bus.hist_valid) begin
        if (dumpLen == 0) firstCycle <= cycle;
        lastValidCycle        <= cycle;
        dumpCnt[bus.hist_bin] <= int'(bus.hist_count);
        if (int'(bus.hist_bin) != (dumpLen % 256)) orderErr <= orderErr + 1;
        dumpLen <= dumpLen + 1;
      end
      if (bus.hist_last) begin
        lastCount  <= lastCount + 1;
        lastBin    <= int'(bus.hist_bin);
        busyAtLast <= bus.busy;
      end
      if (armed && bus.luma_valid && accCount < TOTAL) begin
        accCount <= accCount + 1;
        if (accCount + 1 == TOTAL) lastPixCycle <= cycle;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Drives one cycle of input and checks the luma output due from 2 cycles ago.
  task automatic applyStimulus(input logic fs, input logic d, input logic [23:0] rgb, input logic [7:0] expL);
    bus.frame_start = fs;
    bus.de          = d;
    bus.rgb_data    = rgb;
    @(posedge clk);
    #1;
    expV2 = expV1;
    expL2 = expL1;
    expV1 = d;
    expL1 = expL;
    if (expV2 || bus.luma_valid) checkOutput("luma_valid", bus.luma_valid, expV2);
    if (expV2) checkOutput("luma_out", bus.luma_out, expL2);
  endtask

  task automatic doReset();
    int n;
    rst             = 1'b1;
    bus.frame_start = 1'b0;
    bus.de          = 1'b0;
    bus.rgb_data    = 24'h0;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    expV1 = 1'b0;
    expV2 = 1'b0;
    armed = 1'b0;
    checkOutput("rst_luma_out", bus.luma_out, 0);
    checkOutput("rst_luma_valid", bus.luma_valid, 0);
    checkOutput("rst_hist_bin", bus.hist_bin, 0);
    checkOutput("rst_hist_count", bus.hist_count, 0);
    checkOutput("rst_hist_valid", bus.hist_valid, 0);
    checkOutput("rst_hist_last", bus.hist_last, 0);
    checkOutput("rst_busy", bus.busy, 1);
    n = 0;
    while (bus.busy && n < 400) begin
      applyStimulus(1'b0, 1'b0, 24'h0, 8'h0);
      n++;
    end
    checkOutput("clear_cycles", n, 256);
  endtask

  function automatic logic [23:0] pixRgb(input int mode, input int i);
    case (mode)
      0:       return 24'hFFFFFF;
      1:       return (i < 64 && (i % 2) == 1) ? 24'h0B0B0B : 24'h0A0A0A;
      2:       return 24'hC8C8C8;
      default: return 24'hFF0000;
    endcase
  endfunction

  function automatic logic [7:0] pixLuma(input int mode, input int i);
    case (mode)
      0:       return 8'd255;
      1:       return (i < 64 && (i % 2) == 1) ? 8'd11 : 8'd10;
      2:       return 8'd200;
      default: return 8'd77;
    endcase
  endfunction

  task automatic setExpected(input int mode);
    for (int b = 0; b < 256; b++) expHist[b] = 0;
    case (mode)
      0: expHist[255] = 128;
      1: begin
        expHist[10] = 96;
        expHist[11] = 32;
      end
      2: expHist[200] = 128;
      default: expHist[77] = 128;
    endcase
  endtask

  // One frame with 2-cycle blanking every 16 pixels; optional mid-frame
  // frame_start at pixel 50 and optional early stop at pixel abortAt.
  task automatic sendFrame(input int mode, input bit pokeAccum, input int abortAt);
    epoch++;
    setExpected(mode);
    checkOutput("busy_idle", bus.busy, 0);
    applyStimulus(1'b1, 1'b0, 24'h0, 8'h0);
    armed = 1'b1;
    checkOutput("busy_after_fs", bus.busy, 1);
    for (int i = 0; i < TOTAL; i++) begin
      if (i == abortAt) break;
      if (i != 0 && (i % 16) == 0) begin
        applyStimulus(1'b0, 1'b0, 24'h0, 8'h0);
        applyStimulus(1'b0, 1'b0, 24'h0, 8'h0);
      end
      applyStimulus(pokeAccum && (i == 50), 1'b1, pixRgb(mode, i), pixLuma(mode, i));
    end
  endtask

  task automatic waitDump(input bit pokeDump);
    bit poked;
    poked = 1'b0;
    for (int n = 0; n < 800 && lastCount == 0; n++) begin
      if (pokeDump && !poked && dumpLen >= 10) begin
        applyStimulus(1'b1, 1'b1, 24'hFFFFFF, 8'd255);
        poked = 1'b1;
      end else begin
        applyStimulus(1'b0, 1'b0, 24'h0, 8'h0);
      end
    end
    checkOutput("dump_seen", lastCount > 0, 1);
    repeat (3) applyStimulus(1'b0, 1'b0, 24'h0, 8'h0);
  endtask

  task automatic checkDump(input string name);
    int sum;
    sum = 0;
    $display("[TB] checking dump %s", name);
    checkOutput("dump_len", dumpLen, 256);
    checkOutput("dump_span", lastValidCycle - firstCycle, 255);
    checkOutput("dump_order_errors", orderErr, 0);
    checkOutput("last_count", lastCount, 1);
    checkOutput("last_bin", lastBin, 255);
    checkOutput("dump_latency", firstCycle - lastPixCycle, 4);
    checkOutput("busy_at_last", busyAtLast, 1);
    checkOutput("busy_after_last", busyAfterLast, 0);
    for (int b = 0; b < 256; b++) begin
      checkOutput($sformatf("%s_bin%0d", name, b), dumpCnt[b], expHist[b]);
      sum += dumpCnt[b];
    end
    checkOutput("bin_sum", sum, TOTAL);
  endtask

  initial begin
    bus.frame_start = 1'b0;
    bus.de          = 1'b0;
    bus.rgb_data    = 24'h0;

    $display("[TB] power-on reset");
    doReset();

    $display("[TB] primary colours while idle");
    applyStimulus(1'b0, 1'b1, 24'hFF0000, 8'd77);
    applyStimulus(1'b0, 1'b1, 24'h00FF00, 8'd149);
    applyStimulus(1'b0, 1'b1, 24'h0000FF, 8'd29);
    applyStimulus(1'b0, 1'b1, 24'h000000, 8'd0);
    repeat (3) applyStimulus(1'b0, 1'b0, 24'h0, 8'h0);

    $display("[TB] white frame");
    sendFrame(0, 1'b0, -1);
    waitDump(1'b0);
    checkDump("white");

    $display("[TB] alternating 10/11 then run of 10");
    sendFrame(1, 1'b0, -1);
    waitDump(1'b0);
    checkDump("alt");

    $display("[TB] two consecutive constant frames");
    sendFrame(2, 1'b0, -1);
    waitDump(1'b0);
    checkDump("gray200");
    sendFrame(3, 1'b0, -1);
    waitDump(1'b0);
    checkDump("red");

    $display("[TB] frame_start during accumulate and dump");
    sendFrame(0, 1'b1, -1);
    waitDump(1'b1);
    checkDump("poked");
    repeat (5) applyStimulus(1'b0, 1'b0, 24'h0, 8'h0);
    checkOutput("fs_in_dump_ignored", bus.busy, 0);

    $display("[TB] reset during accumulate");
    sendFrame(2, 1'b0, 60);
    doReset();
    sendFrame(1, 1'b0, -1);
    waitDump(1'b0);
    checkDump("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
